// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - direct-mapped cache controller with dirty write-back and line fill
// Drives external tag/dirty/data arrays; backing memory is a stallable in-order request port.
module cache_ctrl #(
  parameter int MEM_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        done,
  output logic [15:0] rdata,
  output logic        hit,
  output logic        err,
  output logic [7:0]  arr_index,
  output logic [3:0]  data_we,
  output logic [15:0] data_wdata,
  input  logic [63:0] data_rdata,
  output logic        tag_we,
  output logic [5:0]  tag_wdata,
  input  logic [5:0]  tag_rdata,
  output logic        dirty_we,
  output logic        dirty_wdata,
  input  logic        dirty_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_stall,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata
);

  localparam logic [2:0] LAST_W  = 3'(MEM_WORDS - 1);
  localparam logic [2:0] CNT_END = 3'(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  wcnt_q, wcnt_d, icnt_q, icnt_d, rcnt_q, rcnt_d;
  logic [4:0]  victim_tag_q, victim_tag_d;
  logic        miss_seen_q, miss_seen_d;
  logic [15:0] rdata_q, rdata_d;
  logic        done_q, done_d, hit_q, hit_d, err_q, err_d;

  logic [4:0]  req_tag;
  logic [7:0]  req_index;
  logic [1:0]  req_off;
  logic        req_any, illegal, lookup_hit;

  assign req_tag    = req_addr[15:11];
  assign req_index  = req_addr[10:3];
  assign req_off    = req_addr[2:1];
  assign req_any    = req_rd || req_wr;
  assign illegal    = (req_rd && req_wr) || (req_any && req_addr[0]);
  assign lookup_hit = tag_rdata[5] && (tag_rdata[4:0] == req_tag);

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    icnt_d       = icnt_q;
    rcnt_d       = rcnt_q;
    victim_tag_d = victim_tag_q;
    miss_seen_d  = miss_seen_q;
    rdata_d      = rdata_q;
    done_d       = 1'b0;
    hit_d        = hit_q;
    err_d        = err_q;
    arr_index    = req_index;
    data_we      = 4'b0000;
    data_wdata   = 16'h0000;
    tag_we       = 1'b0;
    tag_wdata    = {1'b1, req_tag};
    dirty_we     = 1'b0;
    dirty_wdata  = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 16'h0000;
    mem_wdata    = 16'h0000;
    case (state_q)
      IDLE: begin
        wcnt_d = 3'd0;
        icnt_d = 3'd0;
        rcnt_d = 3'd0;
        if (illegal) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          hit_d   = 1'b0;
        end else if (req_any && lookup_hit) begin
          if (req_rd) begin
            rdata_d = data_rdata[{req_off, 4'b0000} +: 16];
          end else begin
            data_we     = 4'b0001 << req_off;
            data_wdata  = req_wdata;
            dirty_we    = 1'b1;
            dirty_wdata = 1'b1;
          end
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b0;
          hit_d   = !miss_seen_q;
        end else if (req_any) begin
          miss_seen_d  = 1'b1;
          victim_tag_d = tag_rdata[4:0];
          state_d      = (tag_rdata[5] && dirty_rdata) ? WB : FILL;
        end
      end
      WB: begin
        mem_wr    = 1'b1;
        mem_addr  = {victim_tag_q, req_index, wcnt_q[1:0], 1'b0};
        mem_wdata = data_rdata[{wcnt_q[1:0], 4'b0000} +: 16];
        if (!mem_stall) begin
          wcnt_d = wcnt_q + 3'd1;
          if (wcnt_q == LAST_W) state_d = FILL;
        end
      end
      FILL: begin
        if (icnt_q != CNT_END) begin
          mem_rd   = 1'b1;
          mem_addr = {req_tag, req_index, icnt_q[1:0], 1'b0};
          if (!mem_stall) icnt_d = icnt_q + 3'd1;
        end
        // Tag only becomes valid with the last word, so an aborted fill never exposes partial data.
        if (mem_rvalid && (rcnt_q != CNT_END)) begin
          data_we    = 4'b0001 << rcnt_q[1:0];
          data_wdata = mem_rdata;
          rcnt_d     = rcnt_q + 3'd1;
          if (rcnt_q == LAST_W) begin
            tag_we   = 1'b1;
            dirty_we = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      DONE: begin
        miss_seen_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wcnt_q       <= 3'd0;
      icnt_q       <= 3'd0;
      rcnt_q       <= 3'd0;
      victim_tag_q <= 5'd0;
      miss_seen_q  <= 1'b0;
      rdata_q      <= 16'h0000;
      done_q       <= 1'b0;
      hit_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      icnt_q       <= icnt_d;
      rcnt_q       <= rcnt_d;
      victim_tag_q <= victim_tag_d;
      miss_seen_q  <= miss_seen_d;
      rdata_q      <= rdata_d;
      done_q       <= done_d;
      hit_q        <= hit_d;
      err_q        <= err_d;
    end
  end

  assign done  = done_q;
  assign rdata = rdata_q;
  assign hit   = hit_q;
  assign err   = err_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - scoreboard bench for cache_ctrl with array and backing-memory models
module tb_cache_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_rd = 1'b0, req_wr = 1'b0;
  logic [15:0] req_addr = 16'h0, req_wdata = 16'h0;
  logic        done, hit, err;
  logic [15:0] rdata;
  logic [7:0]  arr_index;
  logic [3:0]  data_we;
  logic [15:0] data_wdata;
  logic [63:0] data_rdata;
  logic        tag_we, dirty_we, dirty_wdata, dirty_rdata;
  logic [5:0]  tag_wdata, tag_rdata;
  logic        mem_rd, mem_wr, mem_stall;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = 16'h0;

  cache_ctrl #(.MEM_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .done(done), .rdata(rdata), .hit(hit), .err(err),
    .arr_index(arr_index), .data_we(data_we), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .tag_we(tag_we), .tag_wdata(tag_wdata), .tag_rdata(tag_rdata),
    .dirty_we(dirty_we), .dirty_wdata(dirty_wdata), .dirty_rdata(dirty_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_stall(mem_stall), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int req_start = 0;
  int errors = 0;
  int checks = 0;
  bit stall_en = 1'b0;
  bit act_seen = 1'b0;
  bit tag_we_seen = 1'b0;
  bit prev_stall_rd = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  logic [3:0]  first_data_we;
  logic        first_dirty_we;
  logic [15:0] first_wdata;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_stall = stall_en && ((cyc - req_start) >= 2) && ((cyc - req_start) <= 4);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Cache arrays: combinational read, synchronous write, cleared by reset.
  logic [5:0]  tag_arr [256];
  logic        dirty_arr [256];
  logic [15:0] dat_arr [4][256];
  assign tag_rdata   = tag_arr[arr_index];
  assign dirty_rdata = dirty_arr[arr_index];
  assign data_rdata  = {dat_arr[3][arr_index], dat_arr[2][arr_index],
                        dat_arr[1][arr_index], dat_arr[0][arr_index]};

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        tag_arr[i]   <= 6'h0;
        dirty_arr[i] <= 1'b0;
        for (int b = 0; b < 4; b++) dat_arr[b][i] <= 16'h0;
      end
    end else begin
      if (tag_we) tag_arr[arr_index] <= tag_wdata;
      if (dirty_we) dirty_arr[arr_index] <= dirty_wdata;
      for (int b = 0; b < 4; b++)
        if (data_we[b]) dat_arr[b][arr_index] <= data_wdata;
    end
  end

  // Backing memory: returns two cycles after acceptance, in order.
  typedef struct { logic [15:0] d; int due; } pend_t;
  pend_t pend[$];
  logic [15:0] bmem [int];
  logic [15:0] rlog[$];
  logic [31:0] wlog[$];

  function automatic logic [15:0] bread(input logic [15:0] a);
    return bmem.exists(int'(a)) ? bmem[int'(a)] : (a ^ 16'hC3C3);
  endfunction

  always @(posedge clk) begin
    pend_t p;
    if (mem_rd && !mem_stall) begin
      p.d = bread(mem_addr);
      p.due = cyc + 2;
      pend.push_back(p);
      rlog.push_back(mem_addr);
    end
    if (mem_wr && !mem_stall) begin
      bmem[int'(mem_addr)] = mem_wdata;
      wlog.push_back({mem_addr, mem_wdata});
    end
    if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
      mem_rvalid <= 1'b1;
      mem_rdata  <= pend[0].d;
      void'(pend.pop_front());
    end else begin
      mem_rvalid <= 1'b0;
    end
  end

  typedef struct { logic [15:0] rdata; logic chk_rd; logic hit; logic err; int lat; } exp_t;
  exp_t sb[$];

  function automatic exp_t mk(input logic [15:0] rd, input logic chk, input logic h,
                              input logic e, input int lat);
    exp_t x;
    x.rdata = rd; x.chk_rd = chk; x.hit = h; x.err = e; x.lat = lat;
    return x;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (|data_we || tag_we || dirty_we || mem_rd || mem_wr) act_seen = 1'b1;
    if (tag_we) tag_we_seen = 1'b1;
    if (rst_n && prev_stall_rd) begin
      check("stall_hold_rd", mem_rd, 1'b1);
      check("stall_hold_addr", mem_addr, prev_addr);
    end
    prev_stall_rd = rst_n && mem_stall && mem_rd;
    prev_addr = mem_addr;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        if (e.chk_rd) check("rdata", rdata, e.rdata);
        check("hit", hit, e.hit);
        check("err", err, e.err);
        check("latency", cyc - req_start, e.lat);
      end
    end
  end

  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] wd, input exp_t e, input bit stall);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    req_rd = rd; req_wr = wr; req_addr = a; req_wdata = wd;
    stall_en = stall; req_start = cyc; act_seen = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    first_data_we = data_we; first_dirty_we = dirty_we; first_wdata = data_wdata;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    if (!got) begin
      check("done_timeout", 1'b0, 1'b1);
      if (sb.size() > 0) void'(sb.pop_back());
    end
    @(posedge clk); #1;
    req_rd = 1'b0; req_wr = 1'b0; stall_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wb_exp [4];
    int nret;
    wb_exp = '{32'h0010_1111, 32'h0012_BEEF, 32'h0014_3333, 32'h0016_4444};
    bmem[16'h0010] = 16'h1111; bmem[16'h0012] = 16'h2222;
    bmem[16'h0014] = 16'h3333; bmem[16'h0016] = 16'h4444;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_done", done, 1'b0);
    check("rst_rdata", rdata, 16'h0);
    check("rst_hit", hit, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_mem", {mem_rd, mem_wr}, 2'b00);
    check("rst_we", {data_we, tag_we, dirty_we}, 6'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Clean miss, then hits within the filled line.
    rlog.delete();
    do_req(1, 0, 16'h0010, 16'h0, mk(16'h1111, 1, 0, 0, 8), 0);
    check("fill_reads", rlog.size(), 4);
    if (rlog.size() == 4) check("fill_addr3", rlog[3], 16'h0016);
    do_req(1, 0, 16'h0010, 16'h0, mk(16'h1111, 1, 1, 0, 1), 0);
    do_req(1, 0, 16'h0012, 16'h0, mk(16'h2222, 1, 1, 0, 1), 0);

    // Write hit dirties the line.
    do_req(0, 1, 16'h0012, 16'hBEEF, mk(16'h0, 0, 1, 0, 1), 0);
    check("wr_hit_data_we", first_data_we, 4'b0010);
    check("wr_hit_dirty_we", first_dirty_we, 1'b1);
    check("wr_hit_wdata", first_wdata, 16'hBEEF);

    // Conflicting tag forces write-back of the dirty victim.
    rlog.delete(); wlog.delete();
    do_req(1, 0, 16'h0812, 16'h0, mk(bread(16'h0812), 1, 0, 0, 12), 0);
    check("wb_count", wlog.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < wlog.size()) check($sformatf("wb_word%0d", i), wlog[i], wb_exp[i]);
    if (rlog.size() > 0) check("wb_fill_addr0", rlog[0], 16'h0810);
    do_req(1, 0, 16'h0812, 16'h0, mk(bread(16'h0812), 1, 1, 0, 1), 0);
    do_req(1, 0, 16'h0012, 16'h0, mk(16'hBEEF, 1, 0, 0, 8), 0);

    // Three stall cycles during fill issue.
    do_req(1, 0, 16'h1020, 16'h0, mk(bread(16'h1020), 1, 0, 0, 11), 1);

    // Illegal requests: no array or memory activity.
    do_req(1, 1, 16'h0010, 16'h0, mk(16'h0, 0, 0, 1, 1), 0);
    check("err_rdwr_quiet", act_seen, 1'b0);
    do_req(1, 0, 16'h0011, 16'h0, mk(16'h0, 0, 0, 1, 1), 0);
    check("err_odd_rd_quiet", act_seen, 1'b0);
    do_req(0, 1, 16'h0011, 16'h1234, mk(16'h0, 0, 0, 1, 1), 0);
    check("err_odd_wr_quiet", act_seen, 1'b0);

    // Write miss applies its data on the re-lookup after the fill.
    do_req(0, 1, 16'h3006, 16'h5A5A, mk(16'h0, 0, 0, 0, 8), 0);
    do_req(1, 0, 16'h3006, 16'h0, mk(16'h5A5A, 1, 1, 0, 1), 0);
    do_req(1, 0, 16'h3000, 16'h0, mk(bread(16'h3000), 1, 1, 0, 1), 0);

    // Reset after two of four returns.
    tag_we_seen = 1'b0;
    @(posedge clk); #1;
    req_rd = 1'b1; req_addr = 16'h2040; req_start = cyc;
    nret = 0;
    for (int i = 0; i < 30 && nret < 2; i++) begin
      @(negedge clk);
      if (mem_rvalid) nret++;
    end
    check("abort_two_returns", nret, 2);
    @(posedge clk); #1 rst_n = 1'b0; req_rd = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_stale_rvalid", mem_rvalid, 1'b1);
    check("abort_data_we", data_we, 4'b0000);
    check("abort_mem_rd", mem_rd, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_rdata", rdata, 16'h0);
    check("abort_tag_we", tag_we_seen, 1'b0);
    repeat (4) @(posedge clk);
    do_req(1, 0, 16'h2040, 16'h0, mk(bread(16'h2040), 1, 0, 0, 8), 0);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
